// File: rtl/result_display.sv
// result_display: signed 16-bit result to decimal on a multiplexed 8-digit active-low 7-segment display.
// Latency: conversion starts on the capture edge, digit registers load 17 edges later (18-cycle back-to-back).
// Backpressure: none; ans is sampled only when idle and ans != last, so changes during a conversion are deferred.
//
// Ports:
//   clock        sole clock, all state on its rising edge
//   reset        synchronous, active-high
//   ans[15:0]    two's-complement result from the arithmetic stage
//   seg[6:0]     segment drive, active-low, {g,f,e,d,c,b,a}
//   dp           decimal point, active-low, held off
//   an[7:0]      digit enables, active-low one-hot, bit 0 = rightmost position
//   busy         high while a conversion (CONVERT or UPDATE) is in flight
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ans,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        busy
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_t          state;
    logic [15:0]     last;
    logic            sign;
    logic [15:0]     mag;
    logic [19:0]     bcd;
    logic [3:0]      bitcnt;

    // Display-side registers: only written on the UPDATE edge, so the scan
    // never sees a partially converted value.
    logic [4:0][3:0] dig;
    logic            neg;

    // Scan state
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       scan;
    logic [2:0]       scan_nxt;

    // ------------------------------------------------------------------
    // Shift-add-3 correction applied to every BCD nibble before each shift
    // ------------------------------------------------------------------
    logic [19:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            last   <= 16'd0;
            sign   <= 1'b0;
            mag    <= 16'd0;
            bcd    <= 20'd0;
            bitcnt <= 4'd0;
            dig    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ans != last) begin
                        last   <= ans;
                        sign   <= ans[15];
                        // 16-bit negate: 0x8000 maps to 32768, which the
                        // unsigned magnitude register holds exactly.
                        mag    <= ans[15] ? (~ans + 16'd1) : ans;
                        bcd    <= 20'd0;
                        bitcnt <= 4'd0;
                        busy   <= 1'b1;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd, mag} <= {bcd_adj[18:0], mag, 1'b0};
                    bitcnt     <= bitcnt + 4'd1;
                    if (bitcnt == 4'd15) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    dig   <= bcd;
                    neg   <= sign;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-position segment content
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // upper_nz[k]: some digit at position k or above is nonzero.
    // upper_nz[5] is always 0 and closes the chain.
    logic [5:0]      upper_nz;
    logic [7:0][6:0] pos_seg;

    always_comb begin
        upper_nz = '0;
        for (int k = 4; k >= 0; k--) begin
            upper_nz[k] = upper_nz[k+1] | (dig[k] != 4'd0);
        end

        pos_seg    = {8{SEG_BLANK}};
        pos_seg[0] = seg_code(dig[0]);
        for (int k = 1; k < 5; k++) begin
            if (upper_nz[k]) begin
                pos_seg[k] = seg_code(dig[k]);
            end
        end
        // Minus floats one place left of the most significant nonzero digit;
        // a zero magnitude never gets a sign.
        for (int k = 1; k < 6; k++) begin
            if (neg && upper_nz[k-1] && !upper_nz[k]) begin
                pos_seg[k] = SEG_MINUS;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit scan: an and seg move together on the same edge
    // ------------------------------------------------------------------
    assign scan_nxt = scan + 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            scan    <= 3'd0;
            an      <= 8'hFE;
            seg     <= 7'h40;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            scan    <= scan_nxt;
            an      <= ~(8'b1 << scan_nxt);
            seg     <= pos_seg[scan_nxt];
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign dp = 1'b1;

endmodule
